// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end. It issues word-addressed reads
// and buffers each returned word, together with its PC, in a DEPTH-entry FIFO for decode.
// A redirect flushes the FIFO and restarts fetch at redirect_pc.
// Optional feature macro: FETCHQ_BYPASS_EN. When defined, a word returning into an empty
// queue is presented on out_* in the same cycle.
//
// state   | meaning
// IDLE    | no read outstanding; waits for FIFO space
// REQ     | read of fetch_pc outstanding on the instruction port
// DISCARD | abandoned read still outstanding; its data will be dropped
module fetch_prefetch_queue #(
    parameter int          WORD_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              readM1,
    output logic [ADDR_W-1:0] address1,
    input  logic [WORD_W-1:0] data1,
    input  logic              mem_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              deq_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [WORD_W-1:0] num_fetched
);
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [WORD_W-1:0] r_num_fetched;

    logic [WORD_W-1:0] r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_accept;
    logic              w_enq;
    logic              w_deq;
    logic [CNT_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_empty  = (r_count == '0);
    // A word is accepted only from a live read; redirect drops it.
    assign w_accept = (r_state == REQ) && mem_ready && !redirect;
    // Redirect overrides any dequeue in the same cycle.
    assign w_deq    = !w_empty && deq_ready && !redirect;
    assign w_pc_inc = r_fetch_pc + ADDR_W'(1);

`ifdef FETCHQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = w_accept && w_empty;
    // A bypassed word taken by decode this cycle never enters the FIFO.
    assign w_enq     = w_accept && !(w_bypass && deq_ready);
    assign out_valid = !w_empty || w_bypass;
    assign out_inst  = w_bypass ? data1  : r_mem_inst[r_rd_ptr];
    assign out_pc    = w_bypass ? r_addr : r_mem_pc[r_rd_ptr];
`else
    assign w_enq     = w_accept;
    assign out_valid = !w_empty;
    assign out_inst  = r_mem_inst[r_rd_ptr];
    assign out_pc    = r_mem_pc[r_rd_ptr];
`endif

    assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

    assign readM1      = r_read;
    assign address1    = r_addr;
    assign num_fetched = r_num_fetched;

    // Fetch sequencer: state, fetch PC, registered read request/address, fetch counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_read        <= 1'b0;
            r_addr        <= C_RESET_PC;
            r_fetch_pc    <= C_RESET_PC;
            r_num_fetched <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        r_addr     <= redirect_pc;
                        r_read     <= 1'b1;
                        r_state    <= REQ;
                    end else if (r_count < C_DEPTH) begin
                        r_addr  <= r_fetch_pc;
                        r_read  <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        if (mem_ready) begin
                            r_addr  <= redirect_pc;
                            r_state <= REQ;
                        end else begin
                            // r_addr keeps the abandoned address until memory completes it.
                            r_state <= DISCARD;
                        end
                    end else if (mem_ready) begin
                        r_fetch_pc    <= w_pc_inc;
                        r_addr        <= w_pc_inc;
                        r_num_fetched <= r_num_fetched + WORD_W'(1);
                        if (w_count_next < C_DEPTH) begin
                            r_state <= REQ;
                        end else begin
                            r_read  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end
                    if (mem_ready) begin
                        r_addr  <= redirect ? redirect_pc : r_fetch_pc;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_read  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO: storage, pointers and occupancy; redirect empties it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem_inst[r_wr_ptr] <= data1;
                r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed stimulus, a queue-based reference model
// checked every cycle, and literal expectations at the key points of each scenario.
module tb_fetch_prefetch_queue;
    localparam int D = 4;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        readM1;
    logic [15:0] address1;
    logic [15:0] data1;
    logic        mem_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        deq_ready;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [15:0] num_fetched;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .WORD_W(16), .ADDR_W(16), .DEPTH(D), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .readM1(readM1), .address1(address1),
        .data1(data1), .mem_ready(mem_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .deq_ready(deq_ready), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .num_fetched(num_fetched)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: fetch mode, queued {inst,pc} entries, next fetch PC, abandoned PC.
    typedef struct packed {logic [15:0] inst; logic [15:0] pc;} ent_t;
    typedef enum {M_IDLE, M_REQ, M_DISC} mode_t;
    ent_t        q[$];
    mode_t       m_mode = M_IDLE;
    logic [15:0] m_fpc  = 16'h0;
    logic [15:0] m_dpc  = 16'h0;
    logic [15:0] m_nf   = 16'h0;
    logic        m_byp;
    int          m_cnt0;

    always @(negedge clk) begin
        if (chk_en) begin
            m_byp = BYP && (m_mode == M_REQ) && mem_ready && !redirect && (q.size() == 0);
            chk("m_readM1", readM1, m_mode != M_IDLE);
            if (m_mode != M_IDLE)
                chk("m_address1", address1, (m_mode == M_DISC) ? m_dpc : m_fpc);
            chk("m_out_valid", out_valid, (q.size() != 0) || m_byp);
            if (m_byp) begin
                chk("m_byp_inst", out_inst, data1);
                chk("m_byp_pc", out_pc, m_fpc);
            end else if (q.size() != 0) begin
                chk("m_out_inst", out_inst, q[0].inst);
                chk("m_out_pc", out_pc, q[0].pc);
            end
            chk("m_num_fetched", num_fetched, m_nf);

            if (!reset_n) begin
                q.delete();
                m_mode = M_IDLE;
                m_fpc  = 16'h0;
                m_nf   = 16'h0;
            end else begin
                m_cnt0 = q.size();
                case (m_mode)
                    M_IDLE: begin
                        if (redirect) begin
                            q.delete();
                            m_fpc  = redirect_pc;
                            m_mode = M_REQ;
                        end else begin
                            if (deq_ready && m_cnt0 != 0) void'(q.pop_front());
                            if (m_cnt0 < D) m_mode = M_REQ;
                        end
                    end
                    M_REQ: begin
                        if (redirect) begin
                            q.delete();
                            m_dpc  = m_fpc;
                            m_fpc  = redirect_pc;
                            m_mode = mem_ready ? M_REQ : M_DISC;
                        end else if (mem_ready) begin
                            if (deq_ready && m_cnt0 != 0) void'(q.pop_front());
                            if (!(m_byp && deq_ready)) q.push_back(ent_t'({data1, m_fpc}));
                            m_fpc  = m_fpc + 16'd1;
                            m_nf   = m_nf + 16'd1;
                            m_mode = (q.size() < D) ? M_REQ : M_IDLE;
                        end else begin
                            if (deq_ready && m_cnt0 != 0) void'(q.pop_front());
                        end
                    end
                    default: begin
                        if (redirect) begin
                            q.delete();
                            m_fpc = redirect_pc;
                        end else if (deq_ready && m_cnt0 != 0) begin
                            void'(q.pop_front());
                        end
                        if (mem_ready) m_mode = M_REQ;
                    end
                endcase
            end
        end
    end

    // Advance one cycle; memory returns a word derived from the address being read.
    task automatic cyc();
        @(posedge clk);
        #1;
        data1 = address1 ^ 16'hA5A5;
    endtask

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0; deq_ready = 1'b0; data1 = 16'h0;
        repeat (3) cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_readM1", readM1, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_num", num_fetched, 0);

        // Fill from reset with an always-ready memory.
        cyc(); reset_n = 1'b1; mem_ready = 1'b1; deq_ready = 1'b0;
        @(negedge clk);
        chk("t1_idle_readM1", readM1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            chk("t1_readM1", readM1, 1);
            chk("t1_addr", address1, i);
        end
        cyc(); deq_ready = 1'b1;
        @(negedge clk);
        chk("t1_full_readM1", readM1, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_pc", out_pc, 0);
        chk("t1_out_inst", out_inst, 16'hA5A5);
        chk("t1_num", num_fetched, 4);

        // Drain while refilling: consecutive PCs at the head, no gaps.
        for (int i = 1; i < 6; i++) begin
            cyc();
            @(negedge clk);
            chk("t2_out_valid", out_valid, 1);
            chk("t2_out_pc", out_pc, i);
            if (i >= 2) chk("t2_addr", address1, i + 2);
        end

        // Redirect with simultaneous ready drops the word.
        cyc(); redirect = 1'b1; redirect_pc = 16'h0005; mem_ready = 1'b1;
        @(negedge clk);
        cyc(); redirect = 1'b0; mem_ready = 1'b0; deq_ready = 1'b0;
        @(negedge clk);
        chk("t4a_out_valid", out_valid, 0);
        chk("t4a_addr", address1, 16'h0005);
        chk("t4a_num", num_fetched, 8);

        // Redirect while the read at 0x0005 is pending.
        redirect = 1'b1; redirect_pc = 16'h0040;
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("t3_out_valid", out_valid, 0);
        chk("t3_hold_addr", address1, 16'h0005);
        chk("t3_hold_read", readM1, 1);
        cyc(); mem_ready = 1'b1;
        @(negedge clk);
        chk("t3_hold_addr2", address1, 16'h0005);
        cyc(); mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_new_addr", address1, 16'h0040);
        chk("t3_num", num_fetched, 8);

        redirect = 1'b1; redirect_pc = 16'h0100; mem_ready = 1'b1;
        cyc(); redirect = 1'b0; mem_ready = 1'b0; deq_ready = 1'b1;
        @(negedge clk);
        chk("t4_addr", address1, 16'h0100);
        chk("t4_num", num_fetched, 8);
        chk("t4_out_valid", out_valid, 0);

        // Three-cycle memory into an empty queue.
        cyc();
        @(negedge clk);
        cyc(); mem_ready = 1'b1;
        @(negedge clk);
        chk("t5_ready_cycle_valid", out_valid, BYP);
        cyc(); mem_ready = 1'b0;
        @(negedge clk);
        chk("t5_next_cycle_valid", out_valid, !BYP);
        chk("t5_num", num_fetched, 9);

        // Two entries queued, then reset during REQ.
        cyc(); deq_ready = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        cyc(); mem_ready = 1'b0;
        @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_pc", out_pc, 16'h0101);
        chk("t6_pre_addr", address1, 16'h0103);
        reset_n = 1'b0;
        cyc(); reset_n = 1'b1;
        @(negedge clk);
        chk("t6_readM1", readM1, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_inst", out_inst, 0);
        chk("t6_out_pc", out_pc, 0);
        chk("t6_num", num_fetched, 0);
        cyc();
        @(negedge clk);
        chk("t6_first_read", readM1, 1);
        chk("t6_first_addr", address1, 0);

        // Mixed ready/dequeue pattern with redirects, including PC wrap at 0xFFFF.
        for (int i = 0; i < 48; i++) begin
            cyc();
            mem_ready   = (i % 3) != 0;
            deq_ready   = (i % 4) != 1;
            redirect    = (i == 17) || (i == 30);
            redirect_pc = (i == 17) ? 16'hFFFE : 16'h0200;
            @(negedge clk);
        end
        cyc(); redirect = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
